// File: rtl/mux_nx1_rr.sv
// N-to-1 registered stream multiplexer with valid/ready handshake.
// Supports fixed software select (mode 0) and round-robin arbitration (mode 1).
module mux_nx1_rr #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  s,
  output logic [W-1:0]   y,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [SW-1:0]  y_sel
);

  logic [W-1:0]  ch [N];
  logic [SW-1:0] ptr;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] cand;
  int unsigned   idx;
  logic          s_ok;
  logic          load;
  logic          xfer;

  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      ch[k] = in[k*W +: W];
    end
  end

  assign s_ok = (32'(s) < N);

  // Round-robin scan starts at ptr and wraps modulo N; first valid channel wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    if (!mode) begin
      if (s_ok && in_valid[s]) begin
        grant_valid = 1'b1;
        grant_idx   = s;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        idx = 32'(ptr) + i;
        if (idx >= N) idx = idx - N;
        cand = SW'(idx);
        if (!grant_valid && in_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign load = !y_valid || y_ready;
  assign xfer = load && grant_valid && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_sel   <= '0;
      y_valid <= 1'b0;
      ptr     <= '0;
    end else if (xfer) begin
      y       <= ch[grant_idx];
      y_sel   <= grant_idx;
      y_valid <= 1'b1;
      if (mode) ptr <= (grant_idx == SW'(N-1)) ? '0 : grant_idx + SW'(1);
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule
